riv_counter_multi: RTL and testbench

Multi-channel, parametrised-width down counter, used wherever several independent timeouts, lane-alignment waits or periodic ticks are needed. Each channel loads a start value and counts down on its own enable. Each channel runs in one of two modes: one-shot, which stops and holds at zero, or auto-reload, which restarts from the loaded value and produces a periodic tick. Unlike the 4-bit primitive counter, one-shot channels never wrap, and each channel provides a single-cycle expiry pulse in addition to its done level.

---
 rtl/riv_counter_pkg.sv | 24 ++
 rtl/riv_counter_chan.sv | 83 ++++++++
 rtl/riv_counter_multi.sv | 76 +++++++
 tb/tb_riv_counter_multi.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riv_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riv_counter_pkg
//  Description : Shared types and legal-range limits for the multi-channel
//                down counter (riv_counter_multi / riv_counter_chan).
//  Revision    : 1.0  initial release
// ============================================================================
package riv_counter_pkg;

    // Per-channel run mode: one-shot stops and holds at zero, auto-reload
    // restarts from the loaded value and produces a periodic tick.
    typedef enum logic {
        RIV_CNT_ONESHOT = 1'b0,
        RIV_CNT_AUTO    = 1'b1
    } riv_cnt_mode_e;

    // Legal parameter ranges, enforced at elaboration in the top.
    localparam int unsigned c_WIDTH_MIN    = 2;
    localparam int unsigned c_WIDTH_MAX    = 32;
    localparam int unsigned c_CHANNELS_MIN = 1;
    localparam int unsigned c_CHANNELS_MAX = 16;

endpackage : riv_counter_pkg
`default_nettype wire

// File: rtl/riv_counter_chan.sv
`default_nettype none
// ============================================================================
//  Module      : riv_counter_chan
//  Description : One down-counter channel. Loads a start value and mode,
//                counts down on enable, and either holds at zero (one-shot)
//                or restarts from the loaded value (auto-reload).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - load strobe (priority over i_enable)
//                i_value       - start value, sampled on i_load
//                i_mode        - run mode, sampled on i_load
//                i_enable      - count enable
//                o_count       - current count (registered)
//                o_done        - high while idle at zero
//                o_expire      - one-cycle pulse when a countdown completes
//  Revision    : 1.0  initial release
// ============================================================================
module riv_counter_chan
    import riv_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_value,
    input  wire riv_cnt_mode_e    i_mode,
    input  wire logic             i_enable,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_done,
    output logic                  o_expire
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    riv_cnt_mode_e    r_mode;
    logic             r_done;
    logic             r_expire;

    logic             w_last;       // the next enabled cycle completes a countdown
    logic [WIDTH-1:0] w_count_dec;

    assign w_last      = (r_count == WIDTH'(1));
    assign w_count_dec = r_count - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
            r_mode   <= RIV_CNT_ONESHOT;
            r_done   <= 1'b1;
            r_expire <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_value;
            r_reload <= i_value;
            r_mode   <= i_mode;
            r_done   <= (i_value == '0);
            r_expire <= 1'b0;
        end else if (i_enable && !r_done) begin
            // With done low the count is always >= 1, so no wrap is possible.
            if (w_last) begin
                r_expire <= 1'b1;
                if (r_mode == RIV_CNT_AUTO) begin
                    // Reload is non-zero here: a zero load would have set done.
                    r_count <= r_reload;
                end else begin
                    r_count <= '0;
                    r_done  <= 1'b1;
                end
            end else begin
                r_count  <= w_count_dec;
                r_expire <= 1'b0;
            end
        end else begin
            r_expire <= 1'b0;
        end
    end

    assign o_count  = r_count;
    assign o_done   = r_done;
    assign o_expire = r_expire;

endmodule : riv_counter_chan
`default_nettype wire

// File: rtl/riv_counter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : riv_counter_multi
//  Description : CHANNELS independent WIDTH-bit down counters with per-channel
//                load/mode/enable, plus a registered AND of all done flags.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - per-channel load strobe
//                i_value       - per-channel start values, channel i at
//                                [i*WIDTH +: WIDTH]
//                i_mode        - per-channel mode bit (riv_cnt_mode_e)
//                i_enable      - per-channel count enable
//                o_count       - per-channel counts, packed like i_value
//                o_done        - per-channel idle-at-zero level
//                o_expire      - per-channel one-cycle expiry pulse
//                o_all_done    - AND of o_done, one cycle later
//  Revision    : 1.0  initial release
// ============================================================================
module riv_counter_multi
    import riv_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic [CHANNELS-1:0]       i_load,
    input  wire logic [CHANNELS*WIDTH-1:0] i_value,
    input  wire logic [CHANNELS-1:0]       i_mode,
    input  wire logic [CHANNELS-1:0]       i_enable,
    output logic      [CHANNELS*WIDTH-1:0] o_count,
    output logic      [CHANNELS-1:0]       o_done,
    output logic      [CHANNELS-1:0]       o_expire,
    output logic                           o_all_done
);

    // Elaboration-time parameter range checks.
    if ((WIDTH < c_WIDTH_MIN) || (WIDTH > c_WIDTH_MAX)) begin : g_bad_width
        $error("riv_counter_multi: WIDTH out of legal range");
    end
    if ((CHANNELS < c_CHANNELS_MIN) || (CHANNELS > c_CHANNELS_MAX)) begin : g_bad_channels
        $error("riv_counter_multi: CHANNELS out of legal range");
    end

    logic [CHANNELS-1:0] w_done;
    logic                r_all_done;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        riv_counter_chan #(
            .WIDTH    (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_load   (i_load[g]),
            .i_value  (i_value[g*WIDTH +: WIDTH]),
            .i_mode   (riv_cnt_mode_e'(i_mode[g])),
            .i_enable (i_enable[g]),
            .o_count  (o_count[g*WIDTH +: WIDTH]),
            .o_done   (w_done[g]),
            .o_expire (o_expire[g])
        );
    end

    // Registered so that o_all_done is glitch-free; lags o_done by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_all_done <= 1'b1;
        end else begin
            r_all_done <= &w_done;
        end
    end

    assign o_done     = w_done;
    assign o_all_done = r_all_done;

endmodule : riv_counter_multi
`default_nettype wire

// File: tb/tb_riv_counter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riv_counter_multi
//  Description : Self-checking bench for riv_counter_multi (WIDTH=16,
//                CHANNELS=4): directed scenarios plus randomised traffic
//                compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_riv_counter_multi;

    localparam int W  = 16;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     ld, md, en;
    logic [W-1:0]      val [CH];
    logic [CH*W-1:0]   val_flat;
    logic [CH*W-1:0]   o_count;
    logic [CH-1:0]     o_done, o_expire;
    logic              o_all_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: remaining count, loaded period, auto flag.
    int m_count  [CH];
    int m_period [CH];
    bit m_auto   [CH];
    bit m_done   [CH];
    bit m_expire [CH];
    bit m_all;

    always #5 clk = ~clk;

    always_comb begin
        val_flat = '0;
        for (int c = 0; c < CH; c++) val_flat[c*W +: W] = val[c];
    end

    riv_counter_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_load     (ld),
        .i_value    (val_flat),
        .i_mode     (md),
        .i_enable   (en),
        .o_count    (o_count),
        .o_done     (o_done),
        .o_expire   (o_expire),
        .o_all_done (o_all_done)
    );

    function automatic int cnt(int c);
        return int'(o_count[c*W +: W]);
    endfunction

    // Model of one clock edge, from the behavioural rules.
    task automatic model_edge();
        bit all_next = 1'b1;
        for (int c = 0; c < CH; c++) all_next &= m_done[c];
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_count[c] = 0; m_period[c] = 0; m_auto[c] = 0;
                m_done[c] = 1; m_expire[c] = 0;
            end else if (ld[c]) begin
                m_count[c] = int'(val[c]); m_period[c] = int'(val[c]);
                m_auto[c] = md[c]; m_done[c] = (val[c] == 0); m_expire[c] = 0;
            end else if (en[c] && !m_done[c]) begin
                m_count[c] = m_count[c] - 1;
                m_expire[c] = (m_count[c] == 0);
                if (m_count[c] == 0) begin
                    if (m_auto[c]) m_count[c] = m_period[c];
                    else           m_done[c]  = 1;
                end
            end else begin
                m_expire[c] = 0;
            end
        end
        m_all = rst ? 1'b1 : all_next;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; ld = '0; en = '0; md = '0;
        for (int c = 0; c < CH; c++) val[c] = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            ld = CH'($urandom); en = CH'($urandom); md = CH'($urandom);
            for (int c = 0; c < CH; c++) val[c] = W'($urandom);
            tick();
        end
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (cnt(c) !== 0 || o_done[c] !== 1'b1 || o_expire[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset ch%0d: count=%0d done=%b expire=%b, required 0/1/0",
                         c, cnt(c), o_done[c], o_expire[c]);
            end
        end
        n_checks++;
        if (o_all_done !== 1'b1) begin
            n_fail++; $display("FAIL reset all_done: got %b, required 1", o_all_done);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (o_all_done !== 1'b1 || o_done !== '1) begin
            n_fail++;
            $display("FAIL post-reset: all_done=%b done=%b, required 1/1111", o_all_done, o_done);
        end
    endtask

    task automatic test_oneshot();
        idle_inputs();
        ld[0] = 1; val[0] = 16'd5; md[0] = 0;
        tick();
        ld = '0; en[0] = 1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_checks++;
            if (cnt(0) !== ((i < 5) ? 5 - i : 0) || o_done[0] !== (i >= 5) ||
                o_expire[0] !== (i == 5) || o_all_done !== m_all) begin
                n_fail++;
                $display("FAIL oneshot step %0d: count=%0d done=%b expire=%b all_done=%b, required %0d/%b/%b/%b",
                         i, cnt(0), o_done[0], o_expire[0], o_all_done,
                         (i < 5) ? 5 - i : 0, i >= 5, i == 5, m_all);
            end
        end
    endtask

    task automatic test_auto();
        int pulses = 0;
        idle_inputs();
        ld[1] = 1; val[1] = 16'd3; md[1] = 1;
        tick();
        ld = '0; en[1] = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            pulses += int'(o_expire[1]);
            n_checks++;
            if (cnt(1) !== ((i % 3 == 0) ? 3 : 3 - (i % 3)) || o_done[1] !== 1'b0 ||
                o_expire[1] !== (i % 3 == 0)) begin
                n_fail++;
                $display("FAIL auto step %0d: count=%0d done=%b expire=%b, required %0d/0/%b",
                         i, cnt(1), o_done[1], o_expire[1],
                         (i % 3 == 0) ? 3 : 3 - (i % 3), i % 3 == 0);
            end
        end
        n_checks++;
        if (pulses != 4) begin
            n_fail++; $display("FAIL auto pulses: got %0d, required 4", pulses);
        end
        idle_inputs();
    endtask

    task automatic test_zero_load();
        int pulses = 0;
        idle_inputs();
        ld[2] = 1; val[2] = 16'd0; md[2] = 1;
        tick();
        n_checks++;
        if (o_done[2] !== 1'b1 || cnt(2) !== 0) begin
            n_fail++; $display("FAIL zero load: done=%b count=%0d, required 1/0", o_done[2], cnt(2));
        end
        ld = '0; en[2] = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pulses += int'(o_expire[2]);
        end
        n_checks++;
        if (pulses != 0 || o_done[2] !== 1'b1) begin
            n_fail++; $display("FAIL zero enables: pulses=%0d done=%b, required 0/1", pulses, o_done[2]);
        end
        idle_inputs();
    endtask

    task automatic test_max_load();
        int first = 0;
        idle_inputs();
        ld[3] = 1; val[3] = 16'hFFFF; md[3] = 0;
        tick();
        ld = '0; en[3] = 1;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (o_expire[3] && first == 0) first = i;
        end
        n_checks++;
        if (first != 65535 || cnt(3) !== 0 || o_done[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL max load: expire after %0d enables, count=%0d done=%b, required 65535/0/1",
                     first, cnt(3), o_done[3]);
        end
        idle_inputs();
    endtask

    task automatic test_load_enable_and_reset();
        idle_inputs();
        ld[0] = 1; val[0] = 16'd4; en[0] = 1;
        tick();
        n_checks++;
        if (cnt(0) !== 4 || o_done[0] !== 1'b0 || o_expire[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL load+enable: count=%0d done=%b expire=%b, required 4/0/0",
                     cnt(0), o_done[0], o_expire[0]);
        end
        ld = '0;
        tick(); tick();
        n_checks++;
        if (cnt(0) !== 2) begin
            n_fail++; $display("FAIL pre-reset count: got %0d, required 2", cnt(0));
        end
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if (cnt(0) !== 0 || o_done[0] !== 1'b1 || o_expire[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset: count=%0d done=%b expire=%b, required 0/1/0",
                     cnt(0), o_done[0], o_expire[0]);
        end
        tick();
        n_checks++;
        if (o_expire !== '0 || o_done[0] !== 1'b1) begin
            n_fail++; $display("FAIL after reset: expire=%b done0=%b, required 0000/1", o_expire, o_done[0]);
        end
        idle_inputs();
    endtask

    task automatic test_reload_mid();
        idle_inputs();
        ld[1] = 1; val[1] = 16'd2;
        ld[2] = 1; val[2] = 16'd6; md[2] = 1;
        tick();
        ld = '0; en = 4'b0110;
        tick();
        n_checks++;
        if (cnt(1) !== 1) begin
            n_fail++; $display("FAIL reload setup: count=%0d, required 1", cnt(1));
        end
        ld[1] = 1; val[1] = 16'd7;
        tick();
        n_checks++;
        if (cnt(1) !== 7 || o_expire[1] !== 1'b0 || o_done[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reload mid: count=%0d expire=%b done=%b, required 7/0/0",
                     cnt(1), o_expire[1], o_done[1]);
        end
        ld = '0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (cnt(c) !== m_count[c] || o_done[c] !== m_done[c] || o_expire[c] !== m_expire[c]) begin
                    n_fail++;
                    $display("FAIL others ch%0d: count=%0d done=%b expire=%b, required %0d/%b/%b",
                             c, cnt(c), o_done[c], o_expire[c], m_count[c], m_done[c], m_expire[c]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < CH; c++) begin
                ld[c]  = ($urandom_range(0, 19) == 0);
                en[c]  = ($urandom_range(0, 3) != 0);
                md[c]  = $urandom_range(0, 1);
                val[c] = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 9));
            end
            tick();
            for (int c = 0; c < CH; c++) begin
                n_checks++;
                if (cnt(c) !== m_count[c] || o_done[c] !== m_done[c] || o_expire[c] !== m_expire[c]) begin
                    n_fail++;
                    $display("FAIL random cyc %0d ch%0d: count=%0d done=%b expire=%b, required %0d/%b/%b",
                             cyc, c, cnt(c), o_done[c], o_expire[c], m_count[c], m_done[c], m_expire[c]);
                end
            end
            n_checks++;
            if (o_all_done !== m_all) begin
                n_fail++;
                $display("FAIL random cyc %0d all_done: got %b, required %b", cyc, o_all_done, m_all);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        for (int c = 0; c < CH; c++) begin
            m_count[c] = 0; m_period[c] = 0; m_auto[c] = 0; m_done[c] = 1; m_expire[c] = 0;
        end
        m_all = 1;
        test_reset();
        test_oneshot();
        test_auto();
        test_zero_load();
        test_load_enable_and_reset();
        test_reload_mid();
        test_max_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_riv_counter_multi
`default_nettype wire
